// File: rtl/decoder_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter_if
//   Request/grant bundle between the requesters and the round-robin arbiter
//   that owns the shared 3-to-8 select resource.
//
//   Signals
//     req        8  level request, bit k = requester k
//     dis        1  1 = no new grant, current grant released
//     gnt        8  one-hot grant (zero when no grant is active)
//     gnt_idx    3  index of the granted requester
//     gnt_valid  1  a grant is active
//     timeout    1  one-cycle pulse: grant ended by hold-limit expiry
//
//   Modports
//     master  requester side: drives req/dis, observes the grant outputs
//     slave   arbiter side:   observes req/dis, drives the grant outputs
// -----------------------------------------------------------------------------
interface decoder_rr_arbiter_if;
  logic [7:0] req;
  logic       dis;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output dis,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  dis,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//   Round-robin arbiter sharing one 3-to-8 select resource among 8 requesters.
//   A winning index is registered and the one-hot grant is decoded from it.
//   A grant is held while its requester keeps requesting, for at most
//   MAX_HOLD cycles, and is always followed by a one-cycle GAP and at least
//   one IDLE cycle before the next grant.
//
//   Parameters
//     MAX_HOLD  max consecutive cycles one grant may be held (>= 1)
//     CNT_W     hold counter width, must be able to represent MAX_HOLD
//
//   Ports
//     clk   in  rising-edge clock
//     rst   in  asynchronous, active-high reset
//     bus   slave modport of decoder_rr_arbiter_if
//           (req, dis in; gnt, gnt_idx, gnt_valid, timeout out, all registered)
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE_C = CNT_W'(1);

  // First requesting index in the circular order ptr, ptr+1, ..., ptr+7.
  // Only meaningful when req_v is non-zero; returns ptr_v otherwise.
  function automatic logic [2:0] rr_pick(input logic [7:0] req_v,
                                         input logic [2:0] ptr_v);
    logic [2:0] idx_v;
    logic [2:0] cand_v;
    logic       found_v;
    idx_v   = ptr_v;
    found_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand_v = ptr_v + 3'(i);
      if (!found_v && req_v[cand_v]) begin
        idx_v   = cand_v;
        found_v = 1'b1;
      end else begin
        idx_v   = idx_v;
      end
    end
    return idx_v;
  endfunction

  // 3-to-8 one-hot decode of the winning index.
  function automatic logic [7:0] idx_decode(input logic [2:0] idx_v);
    return 8'd1 << idx_v;
  endfunction

  state_t            state_r,     state_s;
  logic [2:0]        ptr_r,       ptr_s;
  logic [CNT_W-1:0]  hold_cnt_r,  hold_cnt_s;
  logic [2:0]        gnt_idx_r,   gnt_idx_s;
  logic              gnt_valid_r, gnt_valid_s;
  logic [7:0]        gnt_r,       gnt_s;
  logic              timeout_r,   timeout_s;
  logic [2:0]        winner_s;

  assign winner_s = rr_pick(bus.req, ptr_r);

  // Next-state and next-output logic; every register defaults to holding.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_idx_s   = gnt_idx_r;
    gnt_valid_s = gnt_valid_r;
    gnt_s       = gnt_r;
    timeout_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (!bus.dis && (|bus.req)) begin
          state_s     = ST_GRANT;
          gnt_idx_s   = winner_s;
          gnt_valid_s = 1'b1;
          gnt_s       = idx_decode(winner_s);
          hold_cnt_s  = HOLD_ONE_C;
        end else begin
          state_s     = ST_IDLE;
          gnt_valid_s = 1'b0;
          gnt_s       = 8'd0;
        end
      end

      ST_GRANT: begin
        // Release checks in priority order: dis, request drop, hold expiry.
        // Only an expiry with the request still present flags timeout.
        if (bus.dis || !bus.req[gnt_idx_r] || (hold_cnt_r == HOLD_MAX_C)) begin
          state_s     = ST_GAP;
          gnt_valid_s = 1'b0;
          gnt_s       = 8'd0;
          ptr_s       = gnt_idx_r + 3'd1;
          timeout_s   = !bus.dis && bus.req[gnt_idx_r];
        end else begin
          state_s     = ST_GRANT;
          hold_cnt_s  = hold_cnt_r + HOLD_ONE_C;
        end
      end

      ST_GAP: begin
        // Exactly one cycle; dis and req have no influence here.
        state_s     = ST_IDLE;
        gnt_valid_s = 1'b0;
        gnt_s       = 8'd0;
      end

      default: begin
        // Unreachable encoding: fall back to a safe, grant-free IDLE.
        state_s     = ST_IDLE;
        gnt_valid_s = 1'b0;
        gnt_s       = 8'd0;
        hold_cnt_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 3'd0;
      hold_cnt_r  <= {CNT_W{1'b0}};
      gnt_idx_r   <= 3'd0;
      gnt_valid_r <= 1'b0;
      gnt_r       <= 8'd0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_valid_r <= gnt_valid_s;
      gnt_r       <= gnt_s;
      timeout_r   <= timeout_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule
